// File: rtl/blur_engine.sv
// ---------------------------------------------------------------------------
// blur_engine
//   Streams a WIDTH x HEIGHT grayscale frame from a source pixel memory,
//   applies a horizontal [1 2 1]/4 blur with per-row edge replication and
//   writes the result to a destination pixel memory. Answers a one-cycle
//   blur_start pulse with a one-cycle blur_done pulse.
//
// Optional feature macro: BLUR_ABORT_EN (adds the blur_abort input).
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high reset
//   blur_start  one-cycle start request (sampled only in IDLE)
//   blur_abort  (BLUR_ABORT_EN only) abandon the frame in RUN/FLUSH
//   blur_done   one-cycle completion pulse
//   busy        high in RUN, FLUSH and DONE
//   rd_en       source read strobe
//   rd_addr     source read address, row-major
//   rd_data     source data, valid one cycle after rd_en
//   wr_en       destination write strobe
//   wr_addr     destination write address
//   wr_data     blurred pixel
// ---------------------------------------------------------------------------
module blur_engine #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blur_start,
`ifdef BLUR_ABORT_EN
    input  logic              blur_abort,
`endif
    output logic              blur_done,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_reg, state_next;

    // Read-side counters
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [XW-1:0]     x_reg;

    // Stage 1: read data arriving on rd_data this cycle
    logic              s1_valid_reg;
    logic [ADDR_W-1:0] s1_addr_reg;
    logic [XW-1:0]     s1_x_reg;

    // Stage 2: window L/C held in registers, R comes straight from rd_data
    logic              s2_valid_reg;
    logic [ADDR_W-1:0] s2_addr_reg;
    logic [XW-1:0]     s2_x_reg;
    logic [DATA_W-1:0] l_reg;
    logic [DATA_W-1:0] c_reg;

    // Output registers
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;

    logic              abort_hit;
    logic [DATA_W-1:0] r_pix;
    logic [DATA_W+1:0] sum;

`ifdef BLUR_ABORT_EN
    assign abort_hit = blur_abort && (state_reg == RUN || state_reg == FLUSH);
`else
    assign abort_hit = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (blur_start) state_next = RUN;
            RUN:     if (rd_addr_reg == LAST_ADDR) state_next = FLUSH;
            FLUSH:   if (wr_en_reg && wr_addr_reg == LAST_ADDR) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign blur_done = (state_reg == DONE);
    assign rd_en     = (state_reg == RUN);
    assign rd_addr   = rd_addr_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

    // ---------------- read address / column counter ----------------
    // Counters park at zero whenever no read is pending so the next frame
    // always starts at address 0, column 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_reg <= '0;
            x_reg       <= '0;
        end else if (state_reg == RUN && !abort_hit && rd_addr_reg != LAST_ADDR) begin
            rd_addr_reg <= rd_addr_reg + 1'b1;
            x_reg       <= (x_reg == X_LAST) ? '0 : x_reg + 1'b1;
        end else begin
            rd_addr_reg <= '0;
            x_reg       <= '0;
        end
    end

    // ---------------- pipeline ----------------
    // Right neighbour: at the row end replicate C instead of using the next
    // row's first pixel (or a read that is never issued for the last pixel).
    assign r_pix = (s2_x_reg == X_LAST) ? c_reg : rd_data;
    assign sum   = {2'b00, l_reg} + {1'b0, c_reg, 1'b0} + {2'b00, r_pix}
                 + (DATA_W+2)'(2);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s1_x_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_addr_reg  <= '0;
            s2_x_reg     <= '0;
            l_reg        <= '0;
            c_reg        <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_en && !abort_hit;
            s1_addr_reg  <= rd_addr_reg;
            s1_x_reg     <= x_reg;
            s2_valid_reg <= s1_valid_reg && !abort_hit;
            wr_en_reg    <= s2_valid_reg && !abort_hit;
            if (s1_valid_reg) begin
                s2_addr_reg <= s1_addr_reg;
                s2_x_reg    <= s1_x_reg;
                c_reg       <= rd_data;
                // Left neighbour: at column 0 replicate the pixel itself so
                // the previous row never leaks in.
                l_reg       <= (s1_x_reg == '0) ? rd_data : c_reg;
            end
            if (s2_valid_reg) begin
                wr_addr_reg <= s2_addr_reg;
                wr_data_reg <= sum[DATA_W+1:2];
            end
        end
    end

endmodule

// File: tb/tb_blur_engine.sv
// ---------------------------------------------------------------------------
// tb_blur_engine
//   Directed bench for blur_engine with a 4x2 frame. Source memory is a small
//   array with registered read; expected outputs are hand-computed tables.
// ---------------------------------------------------------------------------
module tb_blur_engine;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk;
    logic          reset;
    logic          blur_start;
`ifdef BLUR_ABORT_EN
    logic          blur_abort;
`endif
    logic          blur_done;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] src     [N];
    logic [DW-1:0] exp_mem [N];

    int n_checks;
    int n_fails;

    blur_engine #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .blur_start (blur_start),
`ifdef BLUR_ABORT_EN
        .blur_abort (blur_abort),
`endif
        .blur_done  (blur_done),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= src[rd_addr[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Called at cycle 0 (just after a posedge); start is driven in cycle 0.
    // Cycle c outputs are sampled 1 time unit after posedge c.
    task automatic run_frame(input string name, input bit extra_starts);
        int wr_seen;
        int done_seen;
        wr_seen   = 0;
        done_seen = 0;
        blur_start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            blur_start = extra_starts && (c == 3 || c == 12);
            check({name, " rd_en"}, 32'(rd_en), 32'(c >= 1 && c <= N));
            if (c >= 1 && c <= N)
                check({name, " rd_addr"}, 32'(rd_addr), 32'(c - 1));
            check({name, " wr_en"}, 32'(wr_en), 32'(c >= 4 && c <= N + 3));
            if (c >= 4 && c <= N + 3) begin
                check({name, " wr_addr"}, 32'(wr_addr), 32'(c - 4));
                check({name, " wr_data"}, 32'(wr_data), 32'(exp_mem[c - 4]));
            end
            check({name, " busy"}, 32'(busy), 32'(c >= 1 && c <= N + 4));
            check({name, " blur_done"}, 32'(blur_done), 32'(c == N + 4));
            if (wr_en) wr_seen++;
            if (blur_done) done_seen++;
        end
        check({name, " write count"}, 32'(wr_seen), 32'(N));
        check({name, " done count"}, 32'(done_seen), 32'd1);
        $display("frame %s: %0d writes, %0d done pulses", name, wr_seen, done_seen);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        blur_start = 1'b1;   // must lose to reset
`ifdef BLUR_ABORT_EN
        blur_abort = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            src[i]     = '0;
            exp_mem[i] = '0;
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",      32'(busy),      32'd0);
        check("reset blur_done", 32'(blur_done), 32'd0);
        check("reset rd_en",     32'(rd_en),     32'd0);
        check("reset wr_en",     32'(wr_en),     32'd0);
        check("reset rd_addr",   32'(rd_addr),   32'd0);
        check("reset wr_addr",   32'(wr_addr),   32'd0);
        check("reset wr_data",   32'(wr_data),   32'd0);
        $display("reset state checked");
        reset      = 1'b0;
        blur_start = 1'b0;
        @(posedge clk);
        #1;
        check("idle busy", 32'(busy), 32'd0);

        // ---- frame A: ramp row + alternating row, extra ignored starts ----
        src = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd200, 8'd0, 8'd200, 8'd0};
        exp_mem = '{8'd1, 8'd4, 8'd8, 8'd11, 8'd150, 8'd100, 8'd100, 8'd50};
        run_frame("A", 1'b1);

        // ---- frame B: all 255, no overflow ----
        for (int i = 0; i < N; i++) begin
            src[i]     = 8'd255;
            exp_mem[i] = 8'd255;
        end
        run_frame("B", 1'b0);

        // ---- frame C: flat row 0 must not pick up row 1 ----
        src = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd200, 8'd0, 8'd200, 8'd0};
        exp_mem = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd150, 8'd100, 8'd100, 8'd50};
        run_frame("C", 1'b0);

        // ---- reset in cycle 5 ----
        blur_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            blur_start = 1'b0;
            reset      = (c == 5);
            if (c == 5) check("rst busy before", 32'(busy), 32'd1);
            if (c >= 6) begin
                check("rst rd_en",     32'(rd_en),     32'd0);
                check("rst wr_en",     32'(wr_en),     32'd0);
                check("rst busy",      32'(busy),      32'd0);
                check("rst blur_done", 32'(blur_done), 32'd0);
            end
        end
        reset = 1'b0;
        $display("mid-frame reset checked");

`ifdef BLUR_ABORT_EN
        // ---- abort in cycle 5 ----
        blur_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            blur_start = 1'b0;
            blur_abort = (c == 5);
            if (c >= 6) begin
                check("abort rd_en",     32'(rd_en),     32'd0);
                check("abort wr_en",     32'(wr_en),     32'd0);
                check("abort busy",      32'(busy),      32'd0);
                check("abort blur_done", 32'(blur_done), 32'd0);
            end
        end
        blur_abort = 1'b0;
        $display("abort checked");
`endif

        // ---- fresh frame after the interrupted one ----
        run_frame("B2", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/blur_engine.md
Name: blur_engine

Overview:
- Responder to the main controller's blur handshake. It accepts a one-cycle `blur_start` pulse and answers with a one-cycle `blur_done` pulse.
- In between it streams a WIDTH x HEIGHT grayscale frame from a source pixel memory. It applies a horizontal [1 2 1]/4 blur with edge replication and writes the result to a destination pixel memory.
- It sits between the frame buffers and the main FSM, feeding the BLUR_WAIT → SHOW_TRANSFORMED transition.

Parameters:
- WIDTH, 640, pixels per row (≥2)
- HEIGHT, 480, rows per frame (≥1)
- DATA_W, 8, bits per pixel
- ADDR_W, 19, memory address width (≥ clog2(WIDTH*HEIGHT))

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- blur_start  in  1  one-cycle start request from main FSM
- blur_done  out  1  one-cycle completion pulse to main FSM
- busy  out  1  high while a frame is being processed
- rd_en  out  1  source memory read strobe
- rd_addr  out  ADDR_W  source read address, linear row-major
- rd_data  in  DATA_W  source data; valid exactly 1 cycle after rd_en
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination write address
- wr_data  out  DATA_W  blurred pixel

Behaviour:
- Reset: state IDLE; `blur_done`, `busy`, `rd_en` and `wr_en` are 0; `rd_addr`, `wr_addr` and `wr_data` are 0. Pipeline valid bits are cleared.
- Reset has priority over every other input, including a simultaneous `blur_start`.
- States:
  - IDLE: `blur_start` → RUN.
  - RUN: issue reads; after the read of address N-1 (N = WIDTH*HEIGHT) → FLUSH.
  - FLUSH: drain the pipeline; after the last write → DONE.
  - DONE: assert `blur_done` for 1 cycle → IDLE.
- `blur_start` is sampled only in IDLE. Pulses in RUN, FLUSH or DONE are ignored and not queued.
- `busy` = 1 in RUN, FLUSH and DONE; otherwise 0.
- RUN: `rd_en` = 1 every cycle; `rd_addr` goes 0, 1, … N-1, one per cycle, with no gaps. The column counter x wraps from WIDTH-1 to 0 at each row boundary.
- Window: registers L (pixel n-1) and C (pixel n). R is pixel n+1, taken directly from `rd_data`.
- Edge replication, per row: at x=0, L := C; at x=WIDTH-1, R := C. Pixels from adjacent rows are never mixed.
- Arithmetic: sum = L + 2C + R + 2, computed in DATA_W+2 bits (no overflow); `wr_data` = sum >> 2, truncated to DATA_W bits.
- Latency: if `rd_addr`=n is issued in cycle t, then `wr_en`=1 with `wr_addr`=n in cycle t+3.
  - Writes are gapless, in address order, and exactly N in total.
- The last pixel uses replication and does not wait for a read of address N.
- Cycle budget, with start sampled in cycle 0:
  - first read in cycle 1
  - last read in cycle N
  - last write in cycle N+3
  - `blur_done` in cycle N+4
  - `busy` falls in cycle N+5
- Reset mid-operation: the next cycle is IDLE with all strobes at 0. No further reads or writes occur and no `blur_done` pulse is issued.
- `wr_en` is never asserted outside RUN/FLUSH. `rd_en` is never asserted outside RUN.

Optional Feature:
- BLUR_ABORT_EN defined:
  - Adds an input port `blur_abort` (1 bit).
  - `blur_abort`=1 in RUN or FLUSH forces IDLE on the next edge. `rd_en` and `wr_en` are 0 from that cycle onward.
  - No `blur_done` pulse is issued; `busy` drops to 0.
  - `blur_abort` in IDLE or DONE has no effect.
- BLUR_ABORT_EN undefined: no port and no abort logic; the run always completes.

Test Plan:
- WIDTH=4, HEIGHT=1, row {0,4,8,12}, pulse `blur_start` → writes {1,4,8,11} to addresses 0..3. Checks edge replication and rounding.
- WIDTH=4, HEIGHT=2, all pixels 255 → eight writes of 255. Checks no overflow and that edge handling at the row boundary is correct.
- WIDTH=4, HEIGHT=2, start in cycle 0 → `rd_addr` 0 in cycle 1 and 7 in cycle 8; `wr_addr` 0 in cycle 4 and 7 in cycle 11; `blur_done`=1 only in cycle 12; `busy` high in cycles 1..12.
- Row 0 = {10,10,10,10}, row 1 = {200,0,200,0} → row 0 writes {10,10,10,10} with no row-1 leakage; row 1 writes {150,100,100,50}.
- Pulse `blur_start` again in cycles 3 and 12 → ignored: still exactly 8 writes and 1 done pulse. Then, after reaching IDLE, a new start runs a fresh frame from address 0.
- Assert `reset` in cycle 5 → from cycle 6, all strobes 0 and `busy`=0, with no `blur_done`. With BLUR_ABORT_EN, `blur_abort` in cycle 5 gives the same result.
